// File: rtl/prf_mp.sv
// Multi-ported physical register file with per-register ready bits, same-cycle
// write forwarding on reads, allocate-clears-ready and a sticky write-collision flag.
module prf_mp #(
    parameter int  PHYS_REGS = 64,
    parameter int  DATA_W    = 32,
    parameter int  NUM_RD    = 4,
    parameter int  NUM_WR    = 2,
    parameter int  NUM_ALLOC = 2,
    localparam int TAG_W     = $clog2(PHYS_REGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_RD*TAG_W-1:0]     rd_tag,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_ready,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*TAG_W-1:0]     wr_tag,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*TAG_W-1:0]  alloc_tag,
    input  logic [PHYS_REGS-1:0]        ready_set_mask,
    output logic                        wr_conflict
);

    logic [TAG_W-1:0]  rd_tag_s    [NUM_RD];
    logic [TAG_W-1:0]  wr_tag_s    [NUM_WR];
    logic [DATA_W-1:0] wr_data_s   [NUM_WR];
    logic [TAG_W-1:0]  alloc_tag_s [NUM_ALLOC];

    logic [DATA_W-1:0]    data_q [PHYS_REGS];
    logic [DATA_W-1:0]    data_d [PHYS_REGS];
    logic [PHYS_REGS-1:0] ready_q;
    logic [PHYS_REGS-1:0] ready_d;
    logic                 conflict_q;
    logic                 conflict_d;

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd_unpack
        assign rd_tag_s[r] = rd_tag[r*TAG_W +: TAG_W];
    end
    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
        assign wr_tag_s[w]  = wr_tag[w*TAG_W +: TAG_W];
        assign wr_data_s[w] = wr_data[w*DATA_W +: DATA_W];
    end
    for (genvar a = 0; a < NUM_ALLOC; a++) begin : g_alloc_unpack
        assign alloc_tag_s[a] = alloc_tag[a*TAG_W +: TAG_W];
    end

    // Tag 0 never matches, which keeps register 0 pinned at data 0 / ready 1.
    function automatic logic wr_hit(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            hit = hit | (wr_en[w] & (wr_tag_s[w] == tag) & (tag != {TAG_W{1'b0}}));
        end
        return hit;
    endfunction

    // Ascending scan so the highest-index matching port is the one that sticks.
    function automatic logic [DATA_W-1:0] wr_value(input logic [TAG_W-1:0] tag);
        logic [DATA_W-1:0] val;
        val = {DATA_W{1'b0}};
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_tag_s[w] == tag)) begin
                val = wr_data_s[w];
            end
        end
        return val;
    endfunction

    function automatic logic alloc_hit(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int a = 0; a < NUM_ALLOC; a++) begin
            hit = hit | (alloc_en[a] & (alloc_tag_s[a] == tag) & (tag != {TAG_W{1'b0}}));
        end
        return hit;
    endfunction

    function automatic logic wr_collision();
        logic hit;
        hit = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                hit = hit | (wr_en[a] & wr_en[b] & (wr_tag_s[a] == wr_tag_s[b])
                             & (wr_tag_s[a] != {TAG_W{1'b0}}));
            end
        end
        return hit;
    endfunction

    // Combinational read ports with same-cycle writeback forwarding.
    always_comb begin
        rd_data  = {(NUM_RD*DATA_W){1'b0}};
        rd_ready = {NUM_RD{1'b0}};
        for (int r = 0; r < NUM_RD; r++) begin
            if (wr_hit(rd_tag_s[r])) begin
                rd_data[r*DATA_W +: DATA_W] = wr_value(rd_tag_s[r]);
                rd_ready[r]                 = 1'b1;
            end else begin
                rd_data[r*DATA_W +: DATA_W] = data_q[rd_tag_s[r]];
                rd_ready[r]                 = ready_q[rd_tag_s[r]];
            end
        end
    end

    // Next state: allocate clear beats write set beats recovery-mask set beats hold.
    always_comb begin
        ready_d = ready_q;
        for (int i = 0; i < PHYS_REGS; i++) begin
            if (alloc_hit(TAG_W'(i))) begin
                ready_d[i] = 1'b0;
            end else if (wr_hit(TAG_W'(i))) begin
                ready_d[i] = 1'b1;
            end else begin
                ready_d[i] = ready_q[i] | ready_set_mask[i];
            end
            if (wr_hit(TAG_W'(i))) begin
                data_d[i] = wr_value(TAG_W'(i));
            end else begin
                data_d[i] = data_q[i];
            end
        end
        conflict_d = conflict_q | wr_collision();
    end

    // State registers; reset returns every register to zero data and ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                data_q[i] <= {DATA_W{1'b0}};
            end
            ready_q    <= {PHYS_REGS{1'b1}};
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                data_q[i] <= data_d[i];
            end
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = conflict_q;

endmodule

// File: doc/prf_mp.md
PRF_MP -- requirements
Module: prf_mp

Interface
REQ-001 Parameter PHYS_REGS, default 64: number of physical registers; power of two, >= 4.
REQ-002 Parameter DATA_W, default 32: register data width.
REQ-003 Parameter NUM_RD, default 4: number of read ports.
REQ-004 Parameter NUM_WR, default 2: number of write (writeback) ports.
REQ-005 Parameter NUM_ALLOC, default 2: number of allocate ports; derived TAG_W = clog2(PHYS_REGS).
REQ-006 clock  in  1  single system clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 rd_tag  in  NUM_RD*TAG_W  read tag per read port.
REQ-009 rd_data  out  NUM_RD*DATA_W  read data per read port.
REQ-010 rd_ready  out  NUM_RD  ready (value produced) flag per read port.
REQ-011 wr_en  in  NUM_WR  write enable per write port.
REQ-012 wr_tag  in  NUM_WR*TAG_W  destination tag per write port.
REQ-013 wr_data  in  NUM_WR*DATA_W  write data per write port.
REQ-014 alloc_en  in  NUM_ALLOC  allocate enable per allocate port (dispatch of a new destination).
REQ-015 alloc_tag  in  NUM_ALLOC*TAG_W  tag being allocated.
REQ-016 ready_set_mask  in  PHYS_REGS  recovery mask; bit i = 1 forces register i ready.
REQ-017 wr_conflict  out  1  sticky error flag: two write ports hit the same nonzero tag in one cycle.

Function
REQ-018 State: data array PHYS_REGS x DATA_W, ready array PHYS_REGS x 1, sticky conflict bit.
REQ-019 Tag 0 is hardwired: reads return data 0 and ready 1; writes, allocates and mask bits to tag 0 are ignored.
REQ-020 Reads are combinational, zero latency, all ports independent.
REQ-021 Read forwarding: if any enabled write port matches a nonzero rd_tag this cycle, rd_data = that port's wr_data and rd_ready = 1.
REQ-022 Multiple matching write ports: the highest-index port wins for both forwarding and the stored value.
REQ-023 Without a write match, rd_data = stored data and rd_ready = stored ready bit.
REQ-024 Allocate and mask inputs do not affect combinational read outputs in the cycle they are applied.
REQ-025 Write: at the clock edge, an enabled nonzero wr_tag stores wr_data and sets its ready bit to 1.
REQ-026 Allocate: at the clock edge, an enabled nonzero alloc_tag clears its ready bit to 0; stored data is unchanged.
REQ-027 Ready-bit priority per register at the clock edge: allocate (clear) > write (set) > ready_set_mask (set) > hold.
REQ-028 A write and an allocate on the same tag in one cycle still update data; the ready bit ends at 0.
REQ-029 Duplicate allocate tags in one cycle are legal and idempotent.
REQ-030 wr_conflict sets at the clock edge when two or more enabled write ports carry the same nonzero tag; it stays 1 until reset.
REQ-031 No backpressure or handshake: every enabled port completes in its cycle.

Reset
REQ-032 On reset low, asynchronously: all data = 0, all ready bits = 1, wr_conflict = 0.
REQ-033 While reset is low: rd_data = 0, rd_ready = 1 and wr_conflict = 0, except where a same-cycle write forwards.
REQ-034 After reset returns high, state updates resume at the first rising clock edge; writes and allocates presented while reset was low are lost.

Verification
REQ-035 Reset then read tags 0, 5 and 63 -> data 0, ready 1 on all ports; wr_conflict = 0.
REQ-036 Allocate tag 7, next cycle read tag 7 -> ready 0. Write tag 7 = 0xDEADBEEF that cycle -> same-cycle forward of 0xDEADBEEF with ready 1; next cycle stored value 0xDEADBEEF, ready 1.
REQ-037 Write port 0 and port 1 both to tag 9 with 0x11 and 0x22 -> forwarded and stored value 0x22; wr_conflict = 1 and stays 1 for 10 or more cycles until reset.
REQ-038 Same cycle: allocate tag 12 and write tag 12 = 0x55 -> next cycle data 0x55, ready 0. Write tag 0 = 0xFF -> read tag 0 returns 0, ready 1.
REQ-039 Allocate tags 3, 4 and 5, then apply ready_set_mask with bits 3 and 5 set -> ready 3 = 1, 4 = 0, 5 = 1. Assert reset mid-sequence -> all ready bits immediately 1.
REQ-040 Run randomized multi-port traffic at NUM_RD = 6, NUM_WR = 3, PHYS_REGS = 128 -> results match a reference model every cycle.
